pipe_out_scheduler: RTL and testbench

PIPE_OUT_SCHEDULER -- requirements
Module: pipe_out_scheduler

---
 rtl/pipe_out_scheduler_pkg.sv | 39 +++
 rtl/pipe_out_scheduler_rr_pick4.sv | 26 ++
 rtl/pipe_out_scheduler.sv | 136 +++++++++++++
 tb/tb_pipe_out_scheduler.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_out_scheduler_pkg.sv
// Shared definitions for the pipe-out block scheduler: FSM encoding, source
// geometry and the layout of the block header word.
package pipe_out_scheduler_pkg;

    localparam int NUM_SRC  = 4;
    localparam int SRC_ID_W = 2;
    localparam int CNT_W    = 12;
    localparam int SEQ_W    = 16;
    localparam int DATA_W   = 32;
    localparam int TAG_W    = 8;

    // Header word: [31:24] tag, [23:18] zero, [17:16] source id, [15:0] sequence
    localparam int HDR_SEQ_LSB = 0;
    localparam int HDR_ID_LSB  = 16;
    localparam int HDR_PAD_LSB = 18;
    localparam int HDR_PAD_W   = 6;
    localparam int HDR_TAG_LSB = 24;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2
    } state_e;

    function automatic logic [DATA_W-1:0] make_header(
        input logic [TAG_W-1:0]    tag,
        input logic [SRC_ID_W-1:0] id,
        input logic [SEQ_W-1:0]    seq
    );
        logic [DATA_W-1:0] w_word;
        w_word = '0;
        w_word[HDR_TAG_LSB +: TAG_W]    = tag;
        w_word[HDR_PAD_LSB +: HDR_PAD_W] = '0;
        w_word[HDR_ID_LSB  +: SRC_ID_W] = id;
        w_word[HDR_SEQ_LSB +: SEQ_W]    = seq;
        return w_word;
    endfunction

endpackage

// File: rtl/pipe_out_scheduler_rr_pick4.sv
// Round-robin picker over four request lines; the search starts at the
// source after i_last and wraps, so i_last itself has the lowest priority.
module rr_pick4
    import pipe_out_scheduler_pkg::*;
(
    input  logic [NUM_SRC-1:0]  i_elig,
    input  logic [SRC_ID_W-1:0] i_last,
    output logic                o_valid,
    output logic [SRC_ID_W-1:0] o_idx
);

    // Walk from the farthest candidate to the nearest so the nearest one wins.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            logic [SRC_ID_W-1:0] w_cand;
            w_cand = i_last + SRC_ID_W'(k);
            if (i_elig[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/pipe_out_scheduler.sv
// Schedules fixed-size blocks from four FWFT source FIFOs onto one pipe-out
// endpoint; each block is a header word followed by BLOCK_WORDS payload words.
module pipe_out_scheduler
    import pipe_out_scheduler_pkg::*;
#(
    parameter int         BLOCK_WORDS = 256,
    parameter logic [7:0] HDR_TAG     = 8'hA5
) (
    input  logic                        okClk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic                        ep_read,
    output logic [DATA_W-1:0]           ep_datain,
    output logic                        ep_ready,
    input  logic [NUM_SRC*CNT_W-1:0]    src_count,
    input  logic [NUM_SRC*DATA_W-1:0]   src_dout,
    output logic [NUM_SRC-1:0]          src_rd,
    output logic [SRC_ID_W-1:0]         gnt_id,
    output logic [SEQ_W-1:0]            underrun_cnt
);

    localparam int                WC_W       = $clog2(BLOCK_WORDS);
    localparam logic [WC_W-1:0]   LAST_WORD  = WC_W'(BLOCK_WORDS - 1);
    localparam logic [CNT_W-1:0]  ELIG_LEVEL = CNT_W'(BLOCK_WORDS);

    state_e                         r_state;
    state_e                         w_state_nxt;
    logic [SRC_ID_W-1:0]            r_gnt_id;
    logic [SRC_ID_W-1:0]            r_last_gnt;
    logic [WC_W-1:0]                r_word_cnt;
    logic [NUM_SRC-1:0][SEQ_W-1:0]  r_seq;
    logic [SEQ_W-1:0]               r_underrun;

    logic [NUM_SRC-1:0]             w_elig;
    logic                           w_pick_valid;
    logic [SRC_ID_W-1:0]            w_pick_idx;
    logic [DATA_W-1:0]              w_src_word;
    logic                           w_grant;
    logic                           w_last_read;

    always_comb begin
        w_elig     = '0;
        w_src_word = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_elig[i] = (src_count[i*CNT_W +: CNT_W] >= ELIG_LEVEL);
            if (r_gnt_id == SRC_ID_W'(i)) begin
                w_src_word = src_dout[i*DATA_W +: DATA_W];
            end
        end
    end

    rr_pick4 u_pick (
        .i_elig  (w_elig),
        .i_last  (r_last_gnt),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    // NOTE: state is only ever written with <= so every flop samples the
    // pre-edge values of its neighbours, independent of process ordering.
    always_ff @(posedge okClk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        ep_datain   = '0;
        ep_ready    = 1'b0;
        src_rd      = '0;
        w_grant     = 1'b0;
        w_last_read = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable && w_pick_valid) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_HEADER;
                end
            end
            ST_HEADER: begin
                ep_ready  = 1'b1;
                ep_datain = make_header(HDR_TAG, r_gnt_id, r_seq[r_gnt_id]);
                if (ep_read) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                ep_ready         = 1'b1;
                ep_datain        = w_src_word;
                src_rd[r_gnt_id] = ep_read;
                if (ep_read && (r_word_cnt == LAST_WORD)) begin
                    w_last_read = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: the per-source sequence numbers are ordinary flops, not a RAM,
    // so they take the async reset like the rest of the control state.
    always_ff @(posedge okClk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt_id   <= '0;
            r_last_gnt <= '1;
            r_word_cnt <= '0;
            r_seq      <= '0;
            r_underrun <= '0;
        end else begin
            if (w_grant) begin
                r_gnt_id <= w_pick_idx;
            end
            if ((r_state == ST_HEADER) && ep_read) begin
                r_word_cnt <= '0;
            end else if ((r_state == ST_DATA) && ep_read) begin
                r_word_cnt <= r_word_cnt + 1'b1;
            end
            if (w_last_read) begin
                r_seq[r_gnt_id] <= r_seq[r_gnt_id] + 1'b1;
                r_last_gnt      <= r_gnt_id;
            end
            if ((r_state == ST_IDLE) && ep_read && (r_underrun != '1)) begin
                r_underrun <= r_underrun + 1'b1;
            end
        end
    end

    assign gnt_id       = r_gnt_id;
    assign underrun_cnt = r_underrun;

endmodule

// File: tb/tb_pipe_out_scheduler.sv
// Randomized bench for pipe_out_scheduler: FIFO queues feed the DUT and a
// block-level model predicts grants, header words and payload order.
module tb_pipe_out_scheduler;

    localparam int BW = 4;

    logic         okClk  = 1'b0;
    logic         rst_n  = 1'b1;
    logic         enable = 1'b0;
    logic         ep_read = 1'b0;
    logic [31:0]  ep_datain;
    logic         ep_ready;
    logic [47:0]  src_count = '0;
    logic [127:0] src_dout  = '0;
    logic [3:0]   src_rd;
    logic [1:0]   gnt_id;
    logic [15:0]  underrun_cnt;

    pipe_out_scheduler #(.BLOCK_WORDS(BW), .HDR_TAG(8'hA5)) dut (
        .okClk        (okClk),
        .rst_n        (rst_n),
        .enable       (enable),
        .ep_read      (ep_read),
        .ep_datain    (ep_datain),
        .ep_ready     (ep_ready),
        .src_count    (src_count),
        .src_dout     (src_dout),
        .src_rd       (src_rd),
        .gnt_id       (gnt_id),
        .underrun_cnt (underrun_cnt)
    );

    always #5 okClk = ~okClk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] fifo_q [4][$];
    int          m_seq [4];
    int          m_last;
    int          rd_pulses;
    logic [31:0] last_hdr;
    logic [31:0] obs_data;
    logic        obs_ready;
    logic [3:0]  obs_rd;
    logic [1:0]  obs_gnt;

    task automatic update_src();
        for (int i = 0; i < 4; i++) begin
            src_count[i*12 +: 12] = 12'(fifo_q[i].size());
            src_dout[i*32 +: 32]  = (fifo_q[i].size() > 0) ? fifo_q[i][0] : 32'h0;
        end
    endtask

    task automatic push_words(input int src, input int n);
        for (int i = 0; i < n; i++) fifo_q[src].push_back($urandom);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_seq[i] = 0;
        m_last = 3;
    endtask

    function automatic int model_pick();
        for (int k = 1; k <= 4; k++) begin
            int id;
            id = (m_last + k) % 4;
            if (fifo_q[id].size() >= BW) return id;
        end
        return -1;
    endfunction

    function automatic logic [31:0] model_hdr(input int id);
        return {8'hA5, 6'b0, 2'(id), 16'(m_seq[id])};
    endfunction

    // One clock: drive at the falling edge, observe 1 ns later, then let the
    // FIFOs pop whatever the DUT strobed on the rising edge.
    task automatic cyc(input logic rd);
        ep_read = rd;
        update_src();
        #1;
        obs_data  = ep_datain;
        obs_ready = ep_ready;
        obs_rd    = src_rd;
        obs_gnt   = gnt_id;
        @(posedge okClk);
        for (int i = 0; i < 4; i++) begin
            if (obs_rd[i] && fifo_q[i].size() > 0) void'(fifo_q[i].pop_front());
        end
        @(negedge okClk);
    endtask

    task automatic reset_dut();
        @(negedge okClk);
        rst_n   = 1'b0;
        enable  = 1'b0;
        ep_read = 1'b0;
        for (int i = 0; i < 4; i++) fifo_q[i].delete();
        update_src();
        model_reset();
        repeat (2) @(negedge okClk);
        rst_n = 1'b1;
    endtask

    // Runs one whole block starting in IDLE; drop_at >= 0 deasserts enable
    // just before that payload word is read.
    task automatic read_block(input int drop_at, output int got_id);
        int          exp_id;
        int          gaps;
        logic [31:0] hdr;
        logic [31:0] words [$];
        exp_id = model_pick();
        got_id = -1;
        n_checks++;
        if (exp_id < 0) begin
            n_fail++;
            $display("FAIL block_setup: no eligible source in model, required one");
            return;
        end
        hdr = model_hdr(exp_id);
        for (int w = 0; w < BW; w++) words.push_back(fifo_q[exp_id][w]);

        cyc(1'b0);
        n_checks++;
        if (obs_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL grant_idle: ep_ready=%b required 0", obs_ready);
        end
        gaps = $urandom_range(0, 2);
        repeat (gaps) begin
            cyc(1'b0);
            n_checks++;
            if (obs_ready !== 1'b1 || obs_data !== hdr) begin
                n_fail++;
                $display("FAIL header_hold: ready=%b data=%h required 1 %h", obs_ready, obs_data, hdr);
            end
        end
        cyc(1'b1);
        last_hdr = obs_data;
        got_id   = int'(obs_gnt);
        n_checks++;
        if (obs_gnt !== 2'(exp_id)) begin
            n_fail++;
            $display("FAIL header_gnt: gnt_id=%0d required %0d", obs_gnt, exp_id);
        end
        n_checks++;
        if (obs_data !== hdr || obs_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL header_word: data=%h ready=%b required %h 1", obs_data, obs_ready, hdr);
        end
        n_checks++;
        if (obs_rd !== 4'b0) begin
            n_fail++;
            $display("FAIL header_rd: src_rd=%b required 0000", obs_rd);
        end

        for (int w = 0; w < BW; w++) begin
            if (w == drop_at) enable = 1'b0;
            gaps = $urandom_range(0, 1);
            repeat (gaps) begin
                cyc(1'b0);
                n_checks++;
                if (obs_rd !== 4'b0 || obs_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL data_gap: src_rd=%b ready=%b required 0000 1", obs_rd, obs_ready);
                end
            end
            cyc(1'b1);
            if (obs_rd[exp_id]) rd_pulses++;
            n_checks++;
            if (obs_data !== words[w]) begin
                n_fail++;
                $display("FAIL data_word: word %0d data=%h required %h", w, obs_data, words[w]);
            end
            n_checks++;
            if (obs_rd !== (4'b1 << exp_id)) begin
                n_fail++;
                $display("FAIL data_rd: word %0d src_rd=%b required %b", w, obs_rd, 4'b1 << exp_id);
            end
        end
        m_seq[exp_id] = (m_seq[exp_id] + 1) % 65536;
        m_last        = exp_id;
    endtask

    task automatic test_reset();
        ep_read = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (ep_ready !== 1'b0 || src_rd !== 4'b0 || ep_datain !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%b rd=%b data=%h required 0 0000 0", ep_ready, src_rd, ep_datain);
        end
        n_checks++;
        if (gnt_id !== 2'd0 || underrun_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_regs: gnt_id=%0d underrun=%0d required 0 0", gnt_id, underrun_cnt);
        end
        ep_read = 1'b0;
        model_reset();
        repeat (2) @(negedge okClk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int id;
        reset_dut();
        enable = 1'b1;
        push_words(2, 4);
        rd_pulses = 0;
        read_block(-1, id);
        n_checks++;
        if (id != 2) begin
            n_fail++;
            $display("FAIL single_gnt: gnt_id=%0d required 2", id);
        end
        n_checks++;
        if (last_hdr !== 32'hA502_0000) begin
            n_fail++;
            $display("FAIL single_hdr: header=%h required a5020000", last_hdr);
        end
        n_checks++;
        if (rd_pulses != 4) begin
            n_fail++;
            $display("FAIL single_pulses: src_rd[2] pulses=%0d required 4", rd_pulses);
        end
        cyc(1'b0);
        n_checks++;
        if (obs_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_drop: ep_ready=%b required 0", obs_ready);
        end
    endtask

    task automatic test_round_robin();
        int order [6] = '{0, 1, 2, 3, 0, 1};
        int seqs  [6] = '{0, 0, 0, 0, 1, 1};
        int id;
        reset_dut();
        enable = 1'b1;
        for (int s = 0; s < 4; s++) push_words(s, 8);
        for (int b = 0; b < 6; b++) begin
            read_block(-1, id);
            n_checks++;
            if (id != order[b] || int'(last_hdr[15:0]) != seqs[b]) begin
                n_fail++;
                $display("FAIL rr_order: block %0d gnt=%0d seq=%0d required %0d %0d",
                         b, id, last_hdr[15:0], order[b], seqs[b]);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_underrun();
        reset_dut();
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(0, 2)) cyc(1'b0);
            cyc(1'b1);
            n_checks++;
            if (obs_data !== 32'h0 || obs_rd !== 4'b0) begin
                n_fail++;
                $display("FAIL underrun_idle: data=%h rd=%b required 0 0000", obs_data, obs_rd);
            end
        end
        n_checks++;
        if (underrun_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL underrun_cnt: underrun_cnt=%0d required 3", underrun_cnt);
        end
    endtask

    task automatic test_enable_drop();
        int id;
        reset_dut();
        enable = 1'b1;
        push_words(0, 4);
        push_words(1, 4);
        read_block(2, id);
        n_checks++;
        if (id != 0) begin
            n_fail++;
            $display("FAIL drop_gnt: gnt_id=%0d required 0", id);
        end
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0);
            n_checks++;
            if (obs_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL drop_hold_idle: cycle %0d ep_ready=%b required 0", i, obs_ready);
            end
        end
        enable = 1'b1;
        read_block(-1, id);
        n_checks++;
        if (id != 1) begin
            n_fail++;
            $display("FAIL drop_resume: gnt_id=%0d required 1", id);
        end
    endtask

    task automatic test_reset_mid();
        int id;
        reset_dut();
        enable = 1'b1;
        push_words(0, 4);
        push_words(1, 4);
        read_block(-1, id);
        cyc(1'b0);
        cyc(1'b1);
        cyc(1'b1);
        cyc(1'b1);
        ep_read = 1'b1;
        update_src();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (ep_ready !== 1'b0 || src_rd !== 4'b0 || ep_datain !== 32'h0 || gnt_id !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_mid: ready=%b rd=%b data=%h gnt=%0d required 0 0000 0 0",
                     ep_ready, src_rd, ep_datain, gnt_id);
        end
        model_reset();
        @(negedge okClk);
        ep_read = 1'b0;
        rst_n   = 1'b1;
        push_words(0, 4);
        push_words(1, 2);
        push_words(3, 4);
        read_block(-1, id);
        n_checks++;
        if (id != 0 || last_hdr[15:0] !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_first_grant: gnt=%0d seq=%h required 0 0000", id, last_hdr[15:0]);
        end
    endtask

    task automatic test_seq_wrap();
        int id;
        reset_dut();
        push_words(3, 8);
        force dut.r_seq = {16'hFFFF, 48'h0};
        #1;
        release dut.r_seq;
        m_seq[3] = 65535;
        enable = 1'b1;
        read_block(-1, id);
        n_checks++;
        if (id != 3 || last_hdr[15:0] !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL wrap_before: gnt=%0d seq=%h required 3 ffff", id, last_hdr[15:0]);
        end
        read_block(-1, id);
        n_checks++;
        if (id != 3 || last_hdr[15:0] !== 16'h0000) begin
            n_fail++;
            $display("FAIL wrap_after: gnt=%0d seq=%h required 3 0000", id, last_hdr[15:0]);
        end
    endtask

    initial begin
        update_src();
        test_reset();
        test_single();
        test_round_robin();
        test_underrun();
        test_enable_drop();
        test_reset_mid();
        test_seq_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule
